// File: rtl/rr_requester.sv
// Per-client job counters feeding a registered request vector to an external arbiter.
// Requests freeze while the arbiter stalls; grant protocol and overflow errors are sticky.
module rr_requester #(
  parameter int CLIENTS = 32,
  parameter int DEPTH   = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [CLIENTS-1:0]                    job_valid,
  output logic [CLIENTS-1:0]                    job_ready,
  input  logic                                  stall,
  input  logic [CLIENTS-1:0]                    grant,
  output logic [CLIENTS-1:0]                    request,
  output logic [$clog2(CLIENTS*DEPTH+1)-1:0]    pending_total,
  output logic                                  overflow,
  output logic                                  grant_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(CLIENTS * DEPTH + 1);

  logic [CW-1:0]      cnt_p0   [CLIENTS];
  logic [CW-1:0]      cnt_next [CLIENTS];
  logic [CLIENTS-1:0] accept;
  logic [CLIENTS-1:0] consume;
  logic [CLIENTS-1:0] req_next;
  logic [PW-1:0]      sum_c;
  logic               ovf_hit;
  logic               gerr_hit;

  // Simultaneous accept and consume cancel; the counter can never wrap because
  // accept needs cnt < DEPTH and consume needs a live request (cnt > 0).
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c,
                                             input logic          inc,
                                             input logic          dec);
    if (inc && !dec) return c + CW'(1);
    if (dec && !inc) return c - CW'(1);
    return c;
  endfunction

  function automatic logic multi_hot(input logic [CLIENTS-1:0] v);
    return (v & (v - CLIENTS'(1))) != '0;
  endfunction

  always_comb begin
    for (int i = 0; i < CLIENTS; i++) begin
      job_ready[i] = (cnt_p0[i] < CW'(DEPTH));
    end
  end

  assign accept  = job_valid & job_ready;
  assign consume = grant & request & {CLIENTS{!stall}};

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      cnt_next[i] = cnt_step(cnt_p0[i], accept[i], consume[i]);
      req_next[i] = stall ? request[i] : (cnt_next[i] != '0);
      sum_c       = sum_c + PW'(cnt_p0[i]);
    end
  end

  assign ovf_hit  = |(job_valid & ~job_ready);
  assign gerr_hit = multi_hot(grant) || (|(grant & ~request));

  // Stage p0: counters, request vector, running total and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CLIENTS; i++) begin
        cnt_p0[i] <= '0;
      end
      request       <= '0;
      pending_total <= '0;
      overflow      <= 1'b0;
      grant_err     <= 1'b0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) begin
        cnt_p0[i] <= cnt_next[i];
      end
      request       <= req_next;
      pending_total <= sum_c;
      overflow      <= overflow | ovf_hit;
      grant_err     <= grant_err | gerr_hit;
    end
  end

endmodule

// File: tb/tb_rr_requester.sv
// Directed bench for rr_requester: stimulus queues expected values, a negedge monitor checks them.
module tb_rr_requester;

  localparam int CLIENTS = 32;
  localparam int DEPTH   = 4;
  localparam int PW      = $clog2(CLIENTS * DEPTH + 1);
  localparam logic [63:0] ALL1 = (64'd1 << CLIENTS) - 64'd1;

  localparam int F_REQ  = 0;
  localparam int F_RDY  = 1;
  localparam int F_PEND = 2;
  localparam int F_OVF  = 3;
  localparam int F_GERR = 4;
  localparam int F_REQV = 5;
  localparam int F_RDYV = 6;

  logic               clock;
  logic               reset;
  logic [CLIENTS-1:0] job_valid;
  logic [CLIENTS-1:0] job_ready;
  logic               stall;
  logic [CLIENTS-1:0] grant;
  logic [CLIENTS-1:0] request;
  logic [PW-1:0]      pending_total;
  logic               overflow;
  logic               grant_err;

  rr_requester #(.CLIENTS(CLIENTS), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .stall         (stall),
    .grant         (grant),
    .request       (request),
    .pending_total (pending_total),
    .overflow      (overflow),
    .grant_err     (grant_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          field;
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int field, input int idx);
    case (field)
      F_REQ:   return 64'(request[idx]);
      F_RDY:   return 64'(job_ready[idx]);
      F_PEND:  return 64'(pending_total);
      F_OVF:   return 64'(overflow);
      F_GERR:  return 64'(grant_err);
      F_REQV:  return 64'(request);
      default: return 64'(job_ready);
    endcase
  endfunction

  task automatic expect_at(input int d, input int field, input int idx,
                           input logic [63:0] val, input string name);
    exp_t e;
    e.cyc   = cyc + d;
    e.field = field;
    e.idx   = idx;
    e.val   = val;
    e.name  = name;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: scoreboard pops plus a watch on request edges
  logic [63:0]        got;
  logic [CLIENTS-1:0] prev_req;
  logic [CLIENTS-1:0] prev_cons;
  logic [CLIENTS-1:0] fell;
  logic [CLIENTS-1:0] rose;
  logic               prev_stall = 1'b0;
  logic               prev_reset = 1'b1;

  always @(negedge clock) begin
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc <= cyc) begin
        checks++;
        got = actual(sbq[k].field, sbq[k].idx);
        if (sbq[k].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                   sbq[k].name, sbq[k].cyc, cyc);
        end else if (got !== sbq[k].val) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                   sbq[k].name, got, sbq[k].val, cyc);
        end
        sbq.delete(k);
      end
    end
    if (!prev_reset) begin
      fell = prev_req & ~request;
      rose = ~prev_req & request;
      if (fell != '0) begin
        checks++;
        if ((fell & ~prev_cons) != '0) begin
          errors++;
          $display("FAIL req_fall_without_grant: fell %0h consumed %0h", fell, prev_cons);
        end
      end
      if (rose != '0) begin
        checks++;
        if (prev_stall) begin
          errors++;
          $display("FAIL req_rise_during_stall: rose %0h stall %0b", rose, prev_stall);
        end
      end
    end
    prev_req   = request;
    prev_cons  = grant & request & {CLIENTS{~stall}};
    prev_stall = stall;
    prev_reset = reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    job_valid = '1;
    grant     = 32'h3;
    stall     = 1'b0;
    step();
    step();
    reset     = 1'b0;
    job_valid = '0;
    grant     = '0;
    expect_at(0, F_REQV, 0, 64'd0, "rst_request");
    expect_at(0, F_PEND, 0, 64'd0, "rst_pending");
    expect_at(0, F_OVF,  0, 64'd0, "rst_overflow");
    expect_at(0, F_GERR, 0, 64'd0, "rst_grant_err");
    expect_at(0, F_RDYV, 0, ALL1,  "rst_ready");
    expect_at(1, F_RDYV, 0, ALL1,  "post_rst_ready");

    // Single job on client 4
    step(); job_valid = 32'h10;
    expect_at(1, F_REQ, 4, 64'd1, "t1_req_rise");
    expect_at(1, F_RDY, 4, 64'd1, "t1_ready");
    step(); job_valid = '0; grant = 32'h10;
    expect_at(1, F_REQ,  4, 64'd0, "t1_req_fall");
    expect_at(1, F_PEND, 0, 64'd1, "t1_pend_lag");
    expect_at(1, F_GERR, 0, 64'd0, "t1_no_gerr");
    step(); grant = '0;
    expect_at(1, F_PEND, 0, 64'd0, "t1_pend_zero");

    // Stall freeze on client 7
    step(); stall = 1'b1;
    step(); job_valid = 32'h80;
    expect_at(0, F_RDY, 7, 64'd1, "t3_ready");
    expect_at(1, F_REQ, 7, 64'd0, "t3_frozen");
    step(); job_valid = '0;
    expect_at(1, F_REQ,  7, 64'd0, "t3_still_frozen");
    expect_at(1, F_PEND, 0, 64'd1, "t3_pend_stalled");
    step(); stall = 1'b0;
    expect_at(1, F_REQ, 7, 64'd1, "t3_release");
    step(); grant = 32'h80;
    expect_at(1, F_REQ, 7, 64'd0, "t3_consumed");
    step(); grant = '0;

    // Grant held through a three-cycle stall on client 2
    step(); job_valid = 32'h4;
    expect_at(1, F_REQ, 2, 64'd1, "t4_req");
    step(); job_valid = '0; grant = 32'h4; stall = 1'b1;
    expect_at(1, F_REQ, 2, 64'd1, "t4_hold1");
    step();
    expect_at(1, F_REQ, 2, 64'd1, "t4_hold2");
    step();
    expect_at(1, F_REQ,  2, 64'd1, "t4_hold3");
    expect_at(1, F_PEND, 0, 64'd1, "t4_cnt_kept");
    step(); stall = 1'b0;
    expect_at(1, F_REQ,  2, 64'd0, "t4_consumed");
    expect_at(2, F_PEND, 0, 64'd0, "t4_pend_zero");
    step(); grant = '0;

    // Simultaneous accept and consume on client 3 at cnt 2
    step(); job_valid = 32'h8;
    step(); job_valid = 32'h8;
    expect_at(0, F_REQ, 3, 64'd1, "t5_req_up");
    step(); job_valid = 32'h8; grant = 32'h8;
    expect_at(1, F_REQ,  3, 64'd1, "t5_req_kept");
    expect_at(1, F_PEND, 0, 64'd2, "t5_pend");
    expect_at(2, F_PEND, 0, 64'd2, "t5_cnt_same");
    step(); job_valid = '0;
    expect_at(1, F_REQ, 3, 64'd1, "t5_drain1");
    step();
    expect_at(1, F_REQ, 3, 64'd0, "t5_drain2");
    step(); grant = '0;
    expect_at(0, F_GERR, 0, 64'd0, "t5_no_gerr");
    expect_at(1, F_PEND, 0, 64'd0, "t5_pend_zero");

    // Fill client 0 and overflow
    for (int k = 1; k <= 5; k++) begin
      step(); job_valid = 32'h1;
      if (k == 4) begin
        expect_at(0, F_RDY, 0, 64'd1, "t2_ready_before_full");
        expect_at(1, F_RDY, 0, 64'd0, "t2_ready_full");
        expect_at(1, F_OVF, 0, 64'd0, "t2_no_ovf_yet");
      end
      if (k == 5) begin
        expect_at(1, F_OVF,  0, 64'd1, "t2_overflow");
        expect_at(1, F_PEND, 0, 64'd4, "t2_pend");
      end
    end
    step(); job_valid = '0;
    expect_at(0, F_REQ,  0, 64'd1, "t2_req");
    expect_at(1, F_PEND, 0, 64'd4, "t2_pend_full");
    expect_at(1, F_OVF,  0, 64'd1, "t2_ovf_sticky");

    // Reset mid-operation while client 0 is granted
    step(); reset = 1'b1; job_valid = '1; grant = 32'h1;
    step();
    step(); reset = 1'b0; job_valid = '0; grant = '0;
    expect_at(0, F_OVF,  0, 64'd0, "rst2_overflow");
    expect_at(0, F_REQV, 0, 64'd0, "rst2_request");
    expect_at(0, F_PEND, 0, 64'd0, "rst2_pending");
    expect_at(0, F_RDYV, 0, ALL1,  "rst2_ready");

    // Multi-hot grant with both clients requesting
    step(); job_valid = 32'h11;
    expect_at(1, F_GERR, 0, 64'd0, "t6_clean");
    step(); job_valid = '0;
    step(); grant = 32'h11;
    expect_at(0, F_REQV, 0, 64'h11, "t6_reqs");
    expect_at(1, F_GERR, 0, 64'd1, "t6_multi");
    step(); grant = '0;
    expect_at(1, F_GERR, 0, 64'd1, "t6_sticky");

    // Stray grant to a client that is not requesting
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    expect_at(0, F_GERR, 0, 64'd0, "rst3_grant_err");
    step(); grant = 32'h200;
    expect_at(1, F_GERR, 0, 64'd1, "t6_stray");
    expect_at(1, F_REQV, 0, 64'd0, "t6_no_request");
    expect_at(1, F_RDYV, 0, ALL1,  "t6_cnt_unchanged");
    expect_at(2, F_PEND, 0, 64'd0, "t6_pend_zero");
    step(); grant = '0;

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_requester.md
RR_REQUESTER -- requirements
Module: rr_requester

Interface
REQ-001 Parameter CLIENTS, default 32, number of requesting clients, SHALL be 2..64.
REQ-002 Parameter DEPTH, default 4, max outstanding jobs per client, SHALL be 1..15.
REQ-003 Port clock  input  1  single clock; all state SHALL update on posedge clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port job_valid  input  CLIENTS  per-client new-job strobe.
REQ-006 Port job_ready  output  CLIENTS  per-client job acceptance; combinational from counter state only.
REQ-007 Port stall  input  1  arbiter stall; while high, request SHALL be frozen.
REQ-008 Port grant  input  CLIENTS  one-hot-or-zero grant from arbiter.
REQ-009 Port request  output  CLIENTS  registered per-client request to arbiter.
REQ-010 Port pending_total  output  $clog2(CLIENTS*DEPTH+1)  registered sum of all per-client counters.
REQ-011 Port overflow  output  1  sticky: job_valid seen while job_ready low.
REQ-012 Port grant_err  output  1  sticky: protocol violation on grant.

Function
REQ-013 Each client i SHALL own a counter cnt[i], width $clog2(DEPTH+1), range 0..DEPTH.
REQ-014 job_ready[i] SHALL equal (cnt[i] < DEPTH).
REQ-015 Job accepted for i when job_valid[i] && job_ready[i].
REQ-016 Grant consumed for i when grant[i] && request[i] && !stall.
REQ-017 cnt[i] next: +1 on accept only; -1 on consume only; unchanged on both or neither.
REQ-018 Accept and consume in same cycle at cnt[i]==DEPTH: job_ready low, so accept impossible; cnt[i] becomes DEPTH-1.
REQ-019 Consume SHALL never occur at cnt[i]==0, since request[i] is high only when cnt[i] was nonzero.
REQ-020 When stall==0, request[i] SHALL load (cnt_next[i] != 0) at the clock edge.
REQ-021 When stall==1, request SHALL hold its value; counters SHALL still accept jobs.
REQ-022 request[i] SHALL fall only in the cycle after a consume for i: no deassertion without grant.
REQ-023 request[i] SHALL rise only in a cycle following stall==0.
REQ-024 pending_total SHALL be registered and equal the sum of cnt[i], one cycle after the counters update.
REQ-025 overflow SHALL set when any job_valid[i] && !job_ready[i]; the job SHALL be dropped.
REQ-026 grant_err SHALL set on either condition: grant has more than one bit set, or grant[i] && !request[i] for some i.
REQ-027 overflow and grant_err SHALL be cleared only by reset.
REQ-028 A grant while stall==1 SHALL NOT be consumed; the same grant SHALL be consumed in the first cycle stall==0.

Reset
REQ-029 While reset is high at posedge clock: all cnt=0, request=0, pending_total=0, overflow=0, grant_err=0.
REQ-030 Inputs during reset cycles SHALL be ignored; no accept, consume, or error flag update.
REQ-031 Reset mid-operation SHALL discard all outstanding jobs, including those for a client currently granted.
REQ-032 job_ready SHALL be all-ones in the cycle after reset deasserts.

Verification
REQ-033 Single job: job_valid[4]=1 for 1 cycle, stall=0 -> request[4]=1 next cycle; grant[4]=1 -> cnt[4]=0, request[4]=0 next cycle, pending_total=0.
REQ-034 Fill and overflow: 5 back-to-back job_valid[0] with DEPTH=4 -> job_ready[0]=0 after 4th accept, overflow=1, cnt[0]=4, pending_total=4.
REQ-035 Stall freeze: stall=1, then job_valid[7]=1 -> request[7] stays 0 while stall high; stall=0 -> request[7]=1 next cycle.
REQ-036 Stalled grant: request[2]=1, cnt[2]=1, grant[2]=1 with stall=1 for 3 cycles -> request[2] held 1, cnt[2]=1; stall=0 -> cnt[2]=0, request[2]=0 next cycle.
REQ-037 Simultaneous accept and consume: cnt[3]=2, job_valid[3]=1 and grant[3]=1 -> cnt[3]=2, request[3]=1.
REQ-038 Protocol errors: grant=32'h0000_0011 -> grant_err=1. After reset, grant[9]=1 with request[9]=0 -> grant_err=1 and cnt unchanged. Assertion check throughout: request bit never falls without a prior-cycle grant.
